// File: rtl/cgra_cmd_pkg.sv
// Shared definitions for the CGRA custom-0 command responder.
// Holds the STC opcode, funct3 selectors, FSM state encoding, the command
// record pushed into the FIFO and the status-word layout.
package cgra_cmd_pkg;

  localparam logic [6:0]  STC_OPCODE = 7'b0001011;

  localparam logic [2:0]  F3_CFG_WR  = 3'b000;
  localparam logic [2:0]  F3_START   = 3'b001;
  localparam logic [2:0]  F3_STATUS  = 3'b010;

  localparam int          STAT_EMPTY_BIT = 0;
  localparam int          STAT_RUN_LSB   = 8;
  localparam int          STAT_RUN_MSB   = 15;

  localparam logic [31:0] RSP_ERROR  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } cmd_t;

  function automatic logic [31:0] status_word(input logic fifo_empty, input logic [7:0] runs);
    logic [31:0] w;
    w = '0;
    w[STAT_EMPTY_BIT] = fifo_empty;
    w[STAT_RUN_MSB:STAT_RUN_LSB] = runs;
    return w;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cgra_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
// Ports: clk_i/rst_i (async active-high), push_i/data_i write side,
// pop_i/data_o read side (data_o shows the head entry), full_o, empty_o,
// count_o current occupancy. Refused pushes (full) and pops (empty) are no-ops.
module cgra_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cgra_cmd_responder.sv
// Custom-0 (STC) command responder sitting between the core and a CGRA.
// Commands are queued in cgra_cmd_fifo and executed one at a time by the FSM:
// configuration writes, CGRA runs with cycle counting, status and error replies.
// Ports: cmd_* command handshake from the core; cfg_* configuration write port;
// cgra_start_o / cgra_done_i run control; rsp_* writeback handshake; busy_o.
//
// state | meaning
// IDLE  | waiting for a queued command; pops head and dispatches
// CFG   | cfg_we_o high for this single cycle
// RUN   | cgra_start_o high for this single cycle, cycle counter cleared
// WAIT  | counting cycles until cgra_done_i
// RESP  | rsp_valid_o held until rsp_ready_i
module cgra_cmd_responder
  import cgra_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_funct3_i,
  input  logic [31:0] cmd_rs1_i,
  input  logic [31:0] cmd_rs2_i,
  input  logic [4:0]  cmd_rd_i,
  output logic        cfg_we_o,
  output logic [7:0]  cfg_addr_o,
  output logic [31:0] cfg_data_o,
  output logic        cgra_start_o,
  input  logic        cgra_done_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [4:0]  rsp_rd_o,
  output logic [31:0] rsp_data_o,
  output logic        busy_o
);

  localparam int CW = $bits(cmd_t);
  localparam int AW = $clog2(DEPTH);

  cmd_t          push_cmd, head;
  logic [CW-1:0] fifo_dout;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [AW:0]   fifo_count;
  logic          unused_rs1_hi;

  state_t        state_q, state_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [7:0]    run_cnt_q, run_cnt_d;
  logic          cfg_we_q, cfg_we_d;
  logic [7:0]    cfg_addr_q, cfg_addr_d;
  logic [31:0]   cfg_data_q, cfg_data_d;
  logic          start_q, start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [4:0]    rsp_rd_q, rsp_rd_d;
  logic [31:0]   rsp_data_q, rsp_data_d;

  assign push_cmd      = {cmd_funct3_i, cmd_rs1_i, cmd_rs2_i, cmd_rd_i};
  assign head          = fifo_dout;
  assign unused_rs1_hi = ^head.rs1[31:8];

  cgra_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .data_i  (push_cmd),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    run_cnt_d   = run_cnt_q;
    cfg_we_d    = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rsp_rd_d = head.rd;
          case (head.funct3)
            F3_CFG_WR: begin
              cfg_we_d   = 1'b1;
              cfg_addr_d = head.rs1[7:0];
              cfg_data_d = head.rs2;
              state_d    = ST_CFG;
            end
            F3_START: begin
              start_d = 1'b1;
              state_d = ST_RUN;
            end
            F3_STATUS: begin
              // Empty bit reports whether anything is queued behind this command.
              rsp_valid_d = 1'b1;
              rsp_data_d  = status_word(fifo_count == (AW+1)'(1), run_cnt_q);
              state_d     = ST_RESP;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = RSP_ERROR;
              state_d     = ST_RESP;
            end
          endcase
        end
      end
      ST_CFG: state_d = ST_IDLE;
      ST_RUN: begin
        cyc_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The done cycle itself counts, so done N cycles after start reports N.
        cyc_d = sat_inc32(cyc_q);
        if (cgra_done_i) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = sat_inc32(cyc_q);
          run_cnt_d   = run_cnt_q + 8'd1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      run_cnt_q   <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      run_cnt_q   <= run_cnt_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign cfg_we_o     = cfg_we_q;
  assign cfg_addr_o   = cfg_addr_q;
  assign cfg_data_o   = cfg_data_q;
  assign cgra_start_o = start_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rd_o     = rsp_rd_q;
  assign rsp_data_o   = rsp_data_q;
  assign busy_o       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_cgra_cmd_responder.sv
// Testbench for cgra_cmd_responder: table-driven single commands, directed
// multi-cycle sequences, then randomized traffic against a transaction model.
module tb_cgra_cmd_responder;
  import cgra_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic [2:0]  cmd_funct3 = '0;
  logic [31:0] cmd_rs1 = '0;
  logic [31:0] cmd_rs2 = '0;
  logic [4:0]  cmd_rd = '0;
  logic        cfg_we_o;
  logic [7:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cgra_start_o;
  logic        cgra_done = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b1;
  logic [4:0]  rsp_rd_o;
  logic [31:0] rsp_data_o;
  logic        busy_o;

  cgra_cmd_responder #(.DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_funct3_i (cmd_funct3),
    .cmd_rs1_i    (cmd_rs1),
    .cmd_rs2_i    (cmd_rs2),
    .cmd_rd_i     (cmd_rd),
    .cfg_we_o     (cfg_we_o),
    .cfg_addr_o   (cfg_addr_o),
    .cfg_data_o   (cfg_data_o),
    .cgra_start_o (cgra_start_o),
    .cgra_done_i  (cgra_done),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_rd_o     (rsp_rd_o),
    .rsp_data_o   (rsp_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        exp_cfg;
    logic [7:0]  exp_addr;
    logic [31:0] exp_cfg_data;
    logic        exp_rsp;
    logic [31:0] exp_rsp_data;
  } vec_t;

  // kind: 0 cfg write, 1 start pulse, 2 run response, 3 fixed response, 4 status response
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  rd;
  } ev_t;

  vec_t vecs[7];
  vec_t c5[5];
  ev_t  cfg_seen[$];
  ev_t  rsp_seen[$];
  ev_t  exp_q[$];
  ev_t  exp_cfg[3];
  ev_t  exp_rsp[3];
  int   start_cyc, done_cyc;
  bit   accepted;

  logic [7:0]  model_runs;
  bit          outstanding;
  bit          issuing;
  int          s_cyc, delay;
  logic [31:0] run_data, act, exp_d;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [4:0] rd);
    cmd_funct3 = f3;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_rd     = rd;
  endtask

  task automatic step_obs();
    step();
    if (cfg_we_o) cfg_seen.push_back('{0, {24'h0, cfg_addr_o}, cfg_data_o, 5'd0});
    if (cgra_start_o) start_cyc = cyc;
    if (rsp_valid_o && rsp_ready) rsp_seen.push_back('{2, 32'h0, rsp_data_o, rsp_rd_o});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    step(); step();
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_cfg_we", cfg_we_o, 0);
    chk("rst_start", cgra_start_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    rst = 1'b0;
    step();

    // ---------------- table-driven single commands ----------------
    vecs[0] = '{F3_CFG_WR, 32'h0000_0012, 32'hDEAD_BEEF, 5'd1, 1'b1, 8'h12, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{F3_CFG_WR, 32'hABCD_0134, 32'h0000_0000, 5'd0, 1'b1, 8'h34, 32'h0000_0000, 1'b0, 32'h0};
    vecs[2] = '{F3_CFG_WR, 32'h0000_00FF, 32'hFFFF_FFFF, 5'd2, 1'b1, 8'hFF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[3] = '{3'b111,    32'h1,         32'h2,         5'd3, 1'b0, 8'h00, 32'h0, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{3'b011,    32'h5,         32'h6,         5'd31,1'b0, 8'h00, 32'h0, 1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{3'b100,    32'h0,         32'h0,         5'd0, 1'b0, 8'h00, 32'h0, 1'b1, 32'hFFFF_FFFF};
    vecs[6] = '{F3_STATUS, 32'h0,         32'h0,         5'd9, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0000_0001};

    for (int i = 0; i < 7; i++) begin
      drive_cmd(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      cmd_valid = 1'b1;
      chk("t_ready", cmd_ready_o, 1);
      step();
      cmd_valid = 1'b0;
      chk("t_n1_cfg_we", cfg_we_o, 0);
      chk("t_n1_rsp_valid", rsp_valid_o, 0);
      step();
      chk("t_n2_cfg_we", cfg_we_o, vecs[i].exp_cfg);
      chk("t_n2_start", cgra_start_o, 0);
      chk("t_n2_rsp_valid", rsp_valid_o, vecs[i].exp_rsp);
      if (vecs[i].exp_cfg) begin
        chk("t_cfg_addr", cfg_addr_o, vecs[i].exp_addr);
        chk("t_cfg_data", cfg_data_o, vecs[i].exp_cfg_data);
      end
      if (vecs[i].exp_rsp) begin
        chk("t_rsp_rd", rsp_rd_o, vecs[i].rd);
        chk("t_rsp_data", rsp_data_o, vecs[i].exp_rsp_data);
      end
      step();
      chk("t_n3_cfg_we", cfg_we_o, 0);
      chk("t_n3_rsp_valid", rsp_valid_o, 0);
      chk("t_n3_busy", busy_o, 0);
    end

    // ---------------- done outside WAIT, then START with 10-cycle run ----------------
    cgra_done = 1'b1;
    step();
    cgra_done = 1'b0;
    chk("a_stray_done_rsp", rsp_valid_o, 0);
    step();
    chk("a_stray_done_busy", busy_o, 0);

    drive_cmd(F3_START, 32'h0, 32'h0, 5'd5);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("a_n1_start", cgra_start_o, 0);
    step();
    chk("a_n2_start", cgra_start_o, 1);
    for (int k = 1; k < 10; k++) begin
      step();
      chk("a_wait_start", cgra_start_o, 0);
      chk("a_wait_rsp", rsp_valid_o, 0);
    end
    step();
    cgra_done = 1'b1;
    step();
    cgra_done = 1'b0;
    chk("a_rsp_valid", rsp_valid_o, 1);
    chk("a_rsp_rd", rsp_rd_o, 5);
    chk("a_rsp_cycles", rsp_data_o, 10);
    step();
    chk("a_rsp_done", rsp_valid_o, 0);

    drive_cmd(F3_STATUS, 32'h0, 32'h0, 5'd2);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("a_status_valid", rsp_valid_o, 1);
    chk("a_status_data", rsp_data_o, 32'h0000_0101);
    step();

    // ---------------- error response with backpressure ----------------
    rsp_ready = 1'b0;
    drive_cmd(3'b111, 32'h0, 32'h0, 5'd3);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("b_hold_valid", rsp_valid_o, 1);
      chk("b_hold_rd", rsp_rd_o, 3);
      chk("b_hold_data", rsp_data_o, 32'hFFFF_FFFF);
      step();
    end
    rsp_ready = 1'b1;
    chk("b_last_valid", rsp_valid_o, 1);
    step();
    chk("b_after_valid", rsp_valid_o, 0);
    chk("b_after_busy", busy_o, 0);

    // ---------------- FIFO fills during a pending START ----------------
    c5[0] = '{F3_CFG_WR, 32'h21, 32'h1111_1111, 5'd0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0};
    c5[1] = '{3'b101,    32'h0,  32'h0,         5'd7, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0};
    c5[2] = '{F3_CFG_WR, 32'h22, 32'h2222_2222, 5'd0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0};
    c5[3] = '{F3_STATUS, 32'h0,  32'h0,         5'd9, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0};
    c5[4] = '{F3_CFG_WR, 32'h23, 32'h3333_3333, 5'd0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0};
    cfg_seen.delete();
    rsp_seen.delete();
    start_cyc = -1;
    drive_cmd(F3_START, 32'h0, 32'h0, 5'd4);
    cmd_valid = 1'b1;
    step_obs();
    cmd_valid = 1'b0;
    step_obs();
    chk("c_start_seen", cgra_start_o, 1);
    for (int i = 0; i < 4; i++) begin
      drive_cmd(c5[i].f3, c5[i].rs1, c5[i].rs2, c5[i].rd);
      cmd_valid = 1'b1;
      chk("c_ready_before_full", cmd_ready_o, 1);
      step_obs();
    end
    drive_cmd(c5[4].f3, c5[4].rs1, c5[4].rs2, c5[4].rd);
    for (int k = 0; k < 3; k++) begin
      chk("c_ready_full", cmd_ready_o, 0);
      step_obs();
    end
    done_cyc = cyc;
    cgra_done = 1'b1;
    step_obs();
    cgra_done = 1'b0;
    accepted = 1'b0;
    for (int t = 0; t < 20 && !accepted; t++) begin
      if (cmd_ready_o) accepted = 1'b1;
      step_obs();
    end
    cmd_valid = 1'b0;
    chk("c_fifth_accepted", accepted, 1);
    for (int t = 0; t < 60 && busy_o; t++) step_obs();
    chk("c_drained", busy_o, 0);

    exp_cfg[0] = '{0, 32'h21, 32'h1111_1111, 5'd0};
    exp_cfg[1] = '{0, 32'h22, 32'h2222_2222, 5'd0};
    exp_cfg[2] = '{0, 32'h23, 32'h3333_3333, 5'd0};
    exp_rsp[0] = '{2, 32'h0, 32'(done_cyc - start_cyc), 5'd4};
    exp_rsp[1] = '{2, 32'h0, 32'hFFFF_FFFF, 5'd7};
    exp_rsp[2] = '{2, 32'h0, 32'h0000_0200, 5'd9};
    chk("c_cfg_count", cfg_seen.size(), 3);
    chk("c_rsp_count", rsp_seen.size(), 3);
    for (int i = 0; i < 3 && i < cfg_seen.size(); i++) begin
      chk("c_cfg_addr_order", cfg_seen[i].a, exp_cfg[i].a);
      chk("c_cfg_data_order", cfg_seen[i].d, exp_cfg[i].d);
    end
    for (int i = 0; i < 3 && i < rsp_seen.size(); i++) begin
      chk("c_rsp_rd_order", rsp_seen[i].rd, exp_rsp[i].rd);
      chk("c_rsp_data_order", rsp_seen[i].d, exp_rsp[i].d);
    end

    // ---------------- reset while waiting for the CGRA ----------------
    drive_cmd(F3_START, 32'h0, 32'h0, 5'd6);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("d_cmd_ready", cmd_ready_o, 1);
    chk("d_start", cgra_start_o, 0);
    chk("d_cfg_we", cfg_we_o, 0);
    chk("d_rsp_valid", rsp_valid_o, 0);
    chk("d_rsp_rd", rsp_rd_o, 0);
    chk("d_rsp_data", rsp_data_o, 0);
    chk("d_busy", busy_o, 0);
    step();
    step();
    rst = 1'b0;
    step();
    cgra_done = 1'b1;
    step();
    cgra_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("d_no_rsp", rsp_valid_o, 0);
      chk("d_no_start", cgra_start_o, 0);
      step();
    end
    chk("d_idle", busy_o, 0);
    drive_cmd(F3_STATUS, 32'h0, 32'h0, 5'd1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("d_status_cleared", rsp_data_o, 32'h0000_0001);
    step();

    // ---------------- randomized traffic vs transaction model ----------------
    model_runs  = 8'd0;
    outstanding = 1'b0;
    run_data    = '0;
    s_cyc       = 0;
    delay       = 0;
    exp_q.delete();
    for (int t = 0; t < 1600; t++) begin
      issuing = (t < 1100);
      if (!issuing && exp_q.size() == 0 && !busy_o && !outstanding) break;
      rsp_ready = ($urandom_range(0, 3) != 0);

      if (cfg_we_o) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 0) flag("r_cfg_unexpected");
        else begin
          chk("r_cfg_addr", cfg_addr_o, exp_q[0].a);
          chk("r_cfg_data", cfg_data_o, exp_q[0].d);
          void'(exp_q.pop_front());
        end
      end
      if (cgra_start_o) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 1) flag("r_start_unexpected");
        else begin
          void'(exp_q.pop_front());
          outstanding = 1'b1;
          s_cyc = cyc;
          delay = $urandom_range(1, 12);
        end
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0 || exp_q[0].kind < 2 || (exp_q[0].kind == 2 && outstanding))
          flag("r_rsp_unexpected");
        else begin
          exp_d = (exp_q[0].kind == 2) ? run_data : exp_q[0].d;
          act = rsp_data_o;
          if (exp_q[0].kind == 4) act[0] = 1'b0;
          chk("r_rsp_rd", rsp_rd_o, exp_q[0].rd);
          chk("r_rsp_data", act, exp_d);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end

      if (outstanding && cyc == s_cyc + delay) begin
        cgra_done   = 1'b1;
        run_data    = 32'(delay);
        outstanding = 1'b0;
      end else if (!outstanding && $urandom_range(0, 9) == 0) begin
        cgra_done = 1'b1;
      end else begin
        cgra_done = 1'b0;
      end

      if (issuing && $urandom_range(0, 1) == 1) begin
        drive_cmd(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_valid && cmd_ready_o) begin
        case (cmd_funct3)
          F3_CFG_WR: exp_q.push_back('{0, {24'h0, cmd_rs1[7:0]}, cmd_rs2, 5'd0});
          F3_START: begin
            exp_q.push_back('{1, 32'h0, 32'h0, 5'd0});
            exp_q.push_back('{2, 32'h0, 32'h0, cmd_rd});
            model_runs = model_runs + 8'd1;
          end
          F3_STATUS: exp_q.push_back('{4, 32'h0, {16'h0, model_runs, 8'h0}, cmd_rd});
          default:   exp_q.push_back('{3, 32'h0, 32'hFFFF_FFFF, cmd_rd});
        endcase
      end
      step();
    end
    cmd_valid = 1'b0;
    cgra_done = 1'b0;
    rsp_ready = 1'b1;
    chk("r_all_executed", exp_q.size(), 0);
    chk("r_final_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cgra_cmd_responder.md
CGRA_CMD_RESPONDER -- requirements
Module: cgra_cmd_responder

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 cmd_valid_i  in  1  core issues one custom-0 (opcode 7'b0001011, STC) command.
REQ-006 cmd_ready_o  out  1  responder accepts the command.
REQ-007 cmd_funct3_i  in  3  command selector.
REQ-008 cmd_rs1_i, cmd_rs2_i  in  32 each  source operands.
REQ-009 cmd_rd_i  in  5  destination register tag.
REQ-010 cfg_we_o  out  1; cfg_addr_o  out  8; cfg_data_o  out  32  CGRA configuration write port.
REQ-011 cgra_start_o  out  1  single-cycle start pulse; cgra_done_i  in  1  CGRA completion pulse.
REQ-012 rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_rd_o  out  5; rsp_data_o  out  32  writeback response.
REQ-013 busy_o  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-014 Command accepted on a cycle with cmd_valid_i && cmd_ready_o; {funct3, rs1, rs2, rd} are pushed into the FIFO.
REQ-015 cmd_ready_o = FIFO not full; when full, pushes are refused and no entry is overwritten.
REQ-016 FSM states: IDLE, CFG, RUN, WAIT, RESP.
REQ-017 IDLE: if FIFO non-empty, pop head into holding registers; funct3 3'b000 -> CFG, 3'b001 -> RUN, 3'b010 -> RESP (status), all others -> RESP (error).
REQ-018 CFG: cfg_we_o=1 for exactly one cycle, cfg_addr_o=rs1[7:0], cfg_data_o=rs2; next IDLE; no response issued.
REQ-019 RUN: cgra_start_o=1 for exactly one cycle; clear cycle counter; next WAIT.
REQ-020 WAIT: increment 32-bit cycle counter each cycle, saturating at 0xFFFF_FFFF; on cgra_done_i go to RESP with rsp_data_o = counter value.
REQ-021 Status response data: bit0 = FIFO empty, bits[15:8] = run counter (completed STARTs, 8-bit, wraps 0xFF->0x00), other bits 0.
REQ-022 Error response data = 0xFFFF_FFFF.
REQ-023 RESP: rsp_valid_o held high with stable rsp_rd_o/rsp_data_o until rsp_ready_i; transfer cycle -> IDLE.
REQ-024 Latency: command pushed in cycle N produces cfg_we_o or cgra_start_o in cycle N+2 when FIFO was empty and FSM idle.
REQ-025 FIFO pushes continue during CFG/RUN/WAIT/RESP; push and pop in the same cycle are both honoured and count is unchanged.
REQ-026 cgra_done_i outside WAIT is ignored.
REQ-027 Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit or an occupancy count.

Reset
REQ-028 rst_i asserted: FSM=IDLE, FIFO empty, counters zero; cmd_ready_o=1 and all other outputs 0, regardless of in-flight operation.
REQ-029 A command in flight at reset is discarded; no pulse or response is generated for it after reset.

Structure
REQ-030 Shared package cgra_cmd_pkg holds the STC opcode, funct3 constants (CFG_WR, START, STATUS), FSM state encoding and the status-word bit positions.
REQ-031 FIFO is the single sub-module cgra_cmd_fifo (parameterised DEPTH/width, push/pop/full/empty).

Verification
REQ-032 CFG_WR rs1=0x12, rs2=0xDEADBEEF pushed in cycle N -> cfg_we_o=1 in N+2 only, addr 0x12, data 0xDEADBEEF; no rsp_valid_o.
REQ-033 START, rd=5; cgra_done_i pulsed 10 cycles after cgra_start_o -> rsp_valid_o with rsp_rd_o=5, rsp_data_o=10; run counter=1.
REQ-034 Five back-to-back commands with DEPTH=4 during a pending START -> cmd_ready_o low after the 4th; the 5th is accepted once a pop occurs; all execute in order.
REQ-035 funct3=3'b111, rd=3, with rsp_ready_i low for 4 cycles -> rsp_valid_o and data 0xFFFF_FFFF held stable until ready, then IDLE.
REQ-036 rst_i asserted in WAIT -> all outputs 0 and cmd_ready_o=1 immediately; a later cgra_done_i yields no response.
